// File: rtl/rv32i_wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_wb_trace_fifo
// Purpose  : Captures qualified RV32I writeback events {pc, rd, data} into a
//            small trace FIFO. The FIFO counts retirements and counts entries
//            it has to drop (sticky flag plus a saturating counter).
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_wb_trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wb_valid_i,
  input  logic [4:0]                 wb_rd_addr_i,
  input  logic [31:0]                wb_rd_data_i,
  input  logic [31:0]                wb_pc_i,
  input  logic                       clear_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [31:0]                trace_pc_o,
  output logic [4:0]                 trace_rd_addr_o,
  output logic [31:0]                trace_rd_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic [31:0]                retire_cnt_o
);

  localparam int                AW        = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]         retire_cnt_q, retire_cnt_d;

  logic                qual, pop, push, drop;
  entry_t              head;

  // Push/pop/drop decisions and next-state for pointers and counters.
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    qual         = wb_valid_i && (wb_rd_addr_i != 5'd0);
    pop          = (level_q != '0) && trace_ready_i;
    push         = qual && ((level_q != FULL_LVL) || pop);
    drop         = qual && !push;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    retire_cnt_d = retire_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    if (qual) retire_cnt_d = retire_cnt_q + 32'd1;

    // A drop coinciding with a clear restarts the count at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_i)
        drop_cnt_d = DROP_W'(1);
      else if (drop_cnt_q != DROP_MAX)
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end else if (clear_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Entry storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: wb_pc_i, rd: wb_rd_addr_i, data: wb_rd_data_i};
  end

  assign head            = mem_q[rd_ptr_q];
  assign trace_valid_o   = (level_q != '0);
  assign trace_pc_o      = head.pc;
  assign trace_rd_addr_o = head.rd;
  assign trace_rd_data_o = head.data;
  assign level_o         = level_q;
  assign overflow_o      = overflow_q;
  assign drop_cnt_o      = drop_cnt_q;
  assign retire_cnt_o    = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_wb_trace_fifo
// Purpose  : Self-checking bench for rv32i_wb_trace_fifo with a queue-based
//            reference model and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_wb_trace_fifo;

  localparam int DEPTH    = 8;
  localparam int DROP_W   = 3;
  localparam int DROP_MAX = (1 << DROP_W) - 1;
  localparam int LW       = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wb_valid = 1'b0;
  logic [4:0]        wb_rd = '0;
  logic [31:0]       wb_data = '0;
  logic [31:0]       wb_pc = '0;
  logic              clear = 1'b0;
  logic              ready = 1'b0;
  logic              t_valid;
  logic [31:0]       t_pc;
  logic [4:0]        t_rd;
  logic [31:0]       t_data;
  logic [LW-1:0]     level;
  logic              ovf;
  logic [DROP_W-1:0] drop_cnt;
  logic [31:0]       retire_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t mq[$];
  int   m_drop   = 0;
  bit   m_ovf    = 0;
  int   m_retire = 0;

  rv32i_wb_trace_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_valid_i(wb_valid), .wb_rd_addr_i(wb_rd), .wb_rd_data_i(wb_data), .wb_pc_i(wb_pc),
    .clear_i(clear),
    .trace_valid_o(t_valid), .trace_ready_i(ready),
    .trace_pc_o(t_pc), .trace_rd_addr_o(t_rd), .trace_rd_data_o(t_data),
    .level_o(level), .overflow_o(ovf), .drop_cnt_o(drop_cnt), .retire_cnt_o(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ent_t rand_ent(bit allow_x0);
    ent_t e;
    e.pc   = $urandom & 32'hFFFF_FFFC;
    e.rd   = allow_x0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 31));
    e.data = $urandom;
    return e;
  endfunction

  task automatic drive(ent_t e, bit v);
    wb_valid = v;
    wb_pc    = e.pc;
    wb_rd    = e.rd;
    wb_data  = e.data;
  endtask

  // Advance one clock; the model consumes the inputs seen at the edge.
  task automatic step();
    bit qual, pop, push;
    @(posedge clk);
    qual = wb_valid && (wb_rd != 5'd0);
    pop  = (mq.size() != 0) && ready;
    push = qual && ((mq.size() < DEPTH) || pop);
    if (qual) m_retire++;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back('{pc: wb_pc, rd: wb_rd, data: wb_data});
    if (qual && !push) begin
      m_ovf  = 1;
      m_drop = clear ? 1 : ((m_drop == DROP_MAX) ? DROP_MAX : m_drop + 1);
    end else if (clear) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop = 0; m_ovf = 0; m_retire = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; wb_valid = 0; ready = 0; clear = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Push n entries with the consumer stalled; inputs idle afterwards.
  task automatic push_n(int n);
    ready = 0;
    for (int i = 0; i < n; i++) begin
      drive(rand_ent(0), 1);
      step();
    end
    wb_valid = 0;
  endtask

  // Drain with ready=1 and compare each head against the model.
  task automatic drain(output ent_t last);
    int guard = 0;
    wb_valid = 0; clear = 0; ready = 1;
    last = '0;
    while (mq.size() != 0 && guard < 4 * DEPTH) begin
      total++;
      if (!t_valid || {t_pc, t_rd, t_data} !== mq[0]) begin
        bad++;
        $display("FAIL drain_head: got valid=%0b %h/%0d/%h want %h/%0d/%h",
                 t_valid, t_pc, t_rd, t_data, mq[0].pc, mq[0].rd, mq[0].data);
      end
      last = mq[0];
      step();
      guard++;
    end
    total++;
    if (t_valid !== 1'b0 || level !== '0) begin
      bad++;
      $display("FAIL drain_empty: got valid=%0b level=%0d want 0/0", t_valid, level);
    end
    ready = 0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (t_valid !== 0 || level !== '0 || ovf !== 0 || drop_cnt !== '0 || retire_cnt !== '0) begin
      bad++;
      $display("FAIL reset_state: valid=%0b level=%0d ovf=%0b drop=%0d retire=%0d want all 0",
               t_valid, level, ovf, drop_cnt, retire_cnt);
    end
    apply_reset();
  endtask

  task automatic test_single_write();
    ent_t e;
    ready = 0;
    drive('{pc: 32'h100, rd: 5'd5, data: 32'hDEADBEEF}, 1);
    step();
    wb_valid = 0;
    total++;
    if (t_valid !== 1 || t_pc !== 32'h100 || t_rd !== 5'd5 || t_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_write_fields: valid=%0b pc=%h rd=%0d data=%h want 1/100/5/deadbeef",
               t_valid, t_pc, t_rd, t_data);
    end
    total++;
    if (level !== LW'(1) || retire_cnt !== 32'd1) begin
      bad++;
      $display("FAIL single_write_counts: level=%0d retire=%0d want 1/1", level, retire_cnt);
    end
    step();
    total++;
    if (t_valid !== 1 || t_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_write_hold: valid=%0b data=%h want 1/deadbeef", t_valid, t_data);
    end
    drain(e);
  endtask

  task automatic test_x0_filter();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive('{pc: 32'h200 + 32'(4*i), rd: 5'd0, data: $urandom}, 1);
      step();
    end
    wb_valid = 0;
    total++;
    if (t_valid !== 0 || retire_cnt !== 32'd0 || level !== '0) begin
      bad++;
      $display("FAIL x0_filter: valid=%0b retire=%0d level=%0d want 0/0/0", t_valid, retire_cnt, level);
    end
  endtask

  task automatic test_fill_overflow();
    ent_t e;
    apply_reset();
    push_n(DEPTH + 2);
    total++;
    if (level !== LW'(DEPTH) || ovf !== 1 || drop_cnt !== DROP_W'(2) || retire_cnt !== 32'd10) begin
      bad++;
      $display("FAIL fill_overflow: level=%0d ovf=%0b drop=%0d retire=%0d want 8/1/2/10",
               level, ovf, drop_cnt, retire_cnt);
    end
    total++;
    if (mq.size() != DEPTH) begin
      bad++;
      $display("FAIL fill_model_size: got %0d want %0d", mq.size(), DEPTH);
    end
    drain(e);
  endtask

  task automatic test_full_push_pop();
    ent_t nw, last;
    apply_reset();
    push_n(DEPTH);
    nw = rand_ent(0);
    drive(nw, 1);
    ready = 1;
    step();
    wb_valid = 0; ready = 0;
    total++;
    if (level !== LW'(DEPTH) || ovf !== 0 || drop_cnt !== '0) begin
      bad++;
      $display("FAIL full_push_pop: level=%0d ovf=%0b drop=%0d want 8/0/0", level, ovf, drop_cnt);
    end
    drain(last);
    total++;
    if (last !== nw) begin
      bad++;
      $display("FAIL full_push_pop_last: got %h want %h", last, nw);
    end
  endtask

  task automatic test_clear_drop();
    apply_reset();
    push_n(DEPTH);
    push_n(2);
    drive(rand_ent(0), 1);
    clear = 1;
    step();
    wb_valid = 0;
    total++;
    if (ovf !== 1 || drop_cnt !== DROP_W'(1)) begin
      bad++;
      $display("FAIL clear_with_drop: ovf=%0b drop=%0d want 1/1", ovf, drop_cnt);
    end
    step();
    clear = 0;
    total++;
    if (ovf !== 0 || drop_cnt !== '0) begin
      bad++;
      $display("FAIL clear_alone: ovf=%0b drop=%0d want 0/0", ovf, drop_cnt);
    end
    total++;
    if (level !== LW'(DEPTH) || retire_cnt !== 32'(DEPTH + 3)) begin
      bad++;
      $display("FAIL clear_keeps_state: level=%0d retire=%0d want %0d/%0d",
               level, retire_cnt, DEPTH, DEPTH + 3);
    end
  endtask

  task automatic test_drop_saturate();
    apply_reset();
    push_n(DEPTH + DROP_MAX + 3);
    total++;
    if (drop_cnt !== DROP_W'(DROP_MAX) || ovf !== 1 || retire_cnt !== 32'(DEPTH + DROP_MAX + 3)) begin
      bad++;
      $display("FAIL drop_saturate: drop=%0d ovf=%0b retire=%0d want %0d/1/%0d",
               drop_cnt, ovf, retire_cnt, DROP_MAX, DEPTH + DROP_MAX + 3);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    push_n(5);
    #3;
    total++;
    if (level !== LW'(5)) begin
      bad++;
      $display("FAIL async_pre_level: got %0d want 5", level);
    end
    rst = 1'b1;
    #1;
    total++;
    if (level !== '0 || t_valid !== 0 || retire_cnt !== '0 || ovf !== 0) begin
      bad++;
      $display("FAIL async_reset: level=%0d valid=%0b retire=%0d ovf=%0b want 0/0/0/0",
               level, t_valid, retire_cnt, ovf);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      drive(rand_ent(1), ($urandom_range(0, 9) < 7));
      ready = ($urandom_range(0, 9) < 4);
      clear = ($urandom_range(0, 19) == 0);
      step();
      total++;
      if (t_valid !== (mq.size() != 0) || level !== LW'(mq.size())) begin
        bad++;
        $display("FAIL rand_level[%0d]: valid=%0b level=%0d want %0b/%0d",
                 i, t_valid, level, mq.size() != 0, mq.size());
      end
      if (mq.size() != 0) begin
        total++;
        if ({t_pc, t_rd, t_data} !== mq[0]) begin
          bad++;
          $display("FAIL rand_head[%0d]: got %h/%0d/%h want %h/%0d/%h",
                   i, t_pc, t_rd, t_data, mq[0].pc, mq[0].rd, mq[0].data);
        end
      end
      total++;
      if (ovf !== m_ovf || drop_cnt !== DROP_W'(m_drop) || retire_cnt !== 32'(m_retire)) begin
        bad++;
        $display("FAIL rand_counters[%0d]: ovf=%0b drop=%0d retire=%0d want %0b/%0d/%0d",
                 i, ovf, drop_cnt, retire_cnt, m_ovf, m_drop, m_retire);
      end
    end
    wb_valid = 0; ready = 0; clear = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_x0_filter();
    test_fill_overflow();
    test_full_push_pop();
    test_clear_drop();
    test_drop_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
